// File: rtl/sram_ctrl_pkg.sv
// rtl/sram_ctrl_pkg.sv - shared types and constants for the SRAM initiator
// Purpose: FSM state encoding, SRAM geometry, and a small max helper used to
//          size the phase counter.
// Ports:   none (package).
package sram_ctrl_pkg;

  localparam int SRAM_ADDR_W = 7;
  localparam int SRAM_DATA_W = 32;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_WL_ON,
    ST_PULSE,
    ST_HOLD,
    ST_WL_OFF
  } sram_ctrl_state_t;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sram_phase_timer.sv
// rtl/sram_phase_timer.sv - loadable down-counter timing SETUP and PULSE phases
// Purpose: loaded with a phase length on entry to a timed state; done_o is high
//          during the last cycle of that phase.
// Ports:   clk, rst_n       clock and synchronous active-low reset
//          load_i           load load_val_i this cycle
//          load_val_i       phase length in cycles (>= 1)
//          done_o           current cycle is the last of the phase
module sram_phase_timer #(
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  output logic             done_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // A count of one means the edge ending this cycle closes the phase.
  assign done_o = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/sram_ctrl.sv
// rtl/sram_ctrl.sv - single-word initiator sequencing the pulse-driven 128x32 SRAM
// Purpose: accepts one read/write request at a time and drives address,
//          word-line enable and read/write pulses; returns a one-cycle response.
// Ports:   clk, rst_n                        clock, synchronous active-low reset
//          req_valid/req_ready/req_we/req_addr/req_wdata   request handshake
//          resp_valid/resp_rdata             response strobe and read data
//          sram_addr/sram_addr_ready/sram_read_pulse/sram_write_pulse/sram_datain
//                                            registered SRAM strobes and data
//          sram_dataout                      SRAM output register
module sram_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int SETUP_CYCLES = 1,
  parameter int PULSE_CYCLES = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   req_we,
  input  logic [SRAM_ADDR_W-1:0] req_addr,
  input  logic [SRAM_DATA_W-1:0] req_wdata,
  output logic                   resp_valid,
  output logic [SRAM_DATA_W-1:0] resp_rdata,
  output logic [SRAM_ADDR_W-1:0] sram_addr,
  output logic                   sram_addr_ready,
  output logic                   sram_read_pulse,
  output logic                   sram_write_pulse,
  output logic [SRAM_DATA_W-1:0] sram_datain,
  input  logic [SRAM_DATA_W-1:0] sram_dataout
);

  localparam int CNT_W = $clog2(max2(SETUP_CYCLES, PULSE_CYCLES) + 1);
  localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(SETUP_CYCLES);
  localparam logic [CNT_W-1:0] PULSE_LD = CNT_W'(PULSE_CYCLES);

  sram_ctrl_state_t state_q, state_d;
  logic                   we_q, we_d;
  logic [SRAM_ADDR_W-1:0] addr_q, addr_d;
  logic [SRAM_DATA_W-1:0] datain_q, datain_d;
  logic                   req_ready_q, req_ready_d;
  logic                   ar_q, ar_d;
  logic                   rp_q, rp_d;
  logic                   wp_q, wp_d;
  logic                   resp_valid_q, resp_valid_d;
  logic [SRAM_DATA_W-1:0] rdata_q, rdata_d;
  logic                   tmr_load;
  logic [CNT_W-1:0]       tmr_val;
  logic                   tmr_done;

  sram_phase_timer #(.CNT_W(CNT_W)) u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .done_o     (tmr_done)
  );

  always_comb begin
    state_d      = state_q;
    we_d         = we_q;
    addr_d       = addr_q;
    datain_d     = datain_q;
    req_ready_d  = req_ready_q;
    ar_d         = ar_q;
    rp_d         = rp_q;
    wp_d         = wp_q;
    resp_valid_d = resp_valid_q;
    rdata_d      = rdata_q;
    tmr_load     = 1'b0;
    tmr_val      = '0;
    case (state_q)
      ST_IDLE: begin
        if (req_valid && req_ready_q) begin
          we_d        = req_we;
          addr_d      = req_addr;
          datain_d    = req_wdata;
          req_ready_d = 1'b0;
          tmr_load    = 1'b1;
          tmr_val     = SETUP_LD;
          state_d     = ST_SETUP;
        end
      end
      ST_SETUP: begin
        if (tmr_done) begin
          ar_d    = 1'b1;
          state_d = ST_WL_ON;
        end
      end
      ST_WL_ON: begin
        // Exactly one pulse, chosen by the latched direction.
        wp_d     = we_q;
        rp_d     = !we_q;
        tmr_load = 1'b1;
        tmr_val  = PULSE_LD;
        state_d  = ST_PULSE;
      end
      ST_PULSE: begin
        if (tmr_done) begin
          wp_d    = 1'b0;
          rp_d    = 1'b0;
          state_d = ST_HOLD;
        end
      end
      ST_HOLD: begin
        // SRAM output register updated on the read-pulse fall last edge.
        if (!we_q) begin
          rdata_d = sram_dataout;
        end
        resp_valid_d = 1'b1;
        ar_d         = 1'b0;
        state_d      = ST_WL_OFF;
      end
      ST_WL_OFF: begin
        resp_valid_d = 1'b0;
        req_ready_d  = 1'b1;
        state_d      = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      we_q         <= 1'b0;
      addr_q       <= '0;
      datain_q     <= '0;
      req_ready_q  <= 1'b1;
      ar_q         <= 1'b0;
      rp_q         <= 1'b0;
      wp_q         <= 1'b0;
      resp_valid_q <= 1'b0;
      rdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      datain_q     <= datain_d;
      req_ready_q  <= req_ready_d;
      ar_q         <= ar_d;
      rp_q         <= rp_d;
      wp_q         <= wp_d;
      resp_valid_q <= resp_valid_d;
      rdata_q      <= rdata_d;
    end
  end

  assign req_ready        = req_ready_q;
  assign resp_valid       = resp_valid_q;
  assign resp_rdata       = rdata_q;
  assign sram_addr        = addr_q;
  assign sram_addr_ready  = ar_q;
  assign sram_read_pulse  = rp_q;
  assign sram_write_pulse = wp_q;
  assign sram_datain      = datain_q;

endmodule

// File: tb/tb_sram_ctrl.sv
// tb/tb_sram_ctrl.sv - directed self-checking bench for sram_ctrl
module tb_sram_ctrl;
  import sram_ctrl_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Default-parameter instance
  logic        rst_n, req_valid, req_we, req_ready, resp_valid;
  logic [6:0]  req_addr, sram_addr;
  logic [31:0] req_wdata, resp_rdata, sram_datain, sram_dataout;
  logic        sram_addr_ready, sram_read_pulse, sram_write_pulse;

  sram_ctrl dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .sram_addr(sram_addr),
    .sram_addr_ready(sram_addr_ready), .sram_read_pulse(sram_read_pulse),
    .sram_write_pulse(sram_write_pulse), .sram_datain(sram_datain),
    .sram_dataout(sram_dataout)
  );

  // S=3, P=4 instance
  logic        req_valid2, req_we2, req_ready2, resp_valid2;
  logic [6:0]  req_addr2, sram_addr2;
  logic [31:0] req_wdata2, resp_rdata2, sram_datain2;
  logic [31:0] sram_dataout2 = 32'h0;
  logic        sram_addr_ready2, sram_read_pulse2, sram_write_pulse2;

  sram_ctrl #(.SETUP_CYCLES(3), .PULSE_CYCLES(4)) dut2 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid2), .req_ready(req_ready2),
    .req_we(req_we2), .req_addr(req_addr2), .req_wdata(req_wdata2),
    .resp_valid(resp_valid2), .resp_rdata(resp_rdata2), .sram_addr(sram_addr2),
    .sram_addr_ready(sram_addr_ready2), .sram_read_pulse(sram_read_pulse2),
    .sram_write_pulse(sram_write_pulse2), .sram_datain(sram_datain2),
    .sram_dataout(sram_dataout2)
  );

  // SRAM array model
  logic [31:0] mem [128];
  always @(posedge sram_write_pulse) mem[sram_addr] = sram_datain;
  always @(negedge sram_read_pulse) sram_dataout = mem[sram_addr];

  // Monitor for dut: edge numbers match cyc after the edge
  int acc_cnt = 0, acc_edge = 0, ar_rise = 0, wp_rise = 0, wp_fall = 0;
  int rp_rise = 0, rp_fall = 0, rp_rises = 0, resp_cyc = 0, resp_cnt = 0, viol = 0;
  logic [31:0] resp_data = '0;
  logic ar_p = 0, wp_p = 0, rp_p = 0, rv_p = 0;
  always @(negedge clk) begin
    if (rst_n && req_valid && req_ready) begin acc_edge = cyc + 1; acc_cnt++; end
    if (sram_addr_ready && !ar_p) ar_rise = cyc;
    if (sram_write_pulse && !wp_p) wp_rise = cyc;
    if (!sram_write_pulse && wp_p) wp_fall = cyc;
    if (sram_read_pulse && !rp_p) begin rp_rise = cyc; rp_rises++; end
    if (!sram_read_pulse && rp_p) rp_fall = cyc;
    if (resp_valid) begin
      resp_cyc = cyc; resp_cnt++; resp_data = resp_rdata;
      if (rv_p) viol++;
    end
    if (sram_write_pulse && sram_read_pulse) viol++;
    if ((sram_write_pulse || sram_read_pulse) && !sram_addr_ready) viol++;
    if ((sram_write_pulse2 || sram_read_pulse2) && !sram_addr_ready2) viol++;
    ar_p = sram_addr_ready; wp_p = sram_write_pulse; rp_p = sram_read_pulse; rv_p = resp_valid;
  end

  // Monitor for dut2
  int acc2 = 0, acc2_cnt = 0, ar2_rise = 0, wp2_rise = 0, wp2_fall = 0, resp2_cyc = 0, resp2_cnt = 0;
  logic ar2_p = 0, wp2_p = 0;
  always @(negedge clk) begin
    if (rst_n && req_valid2 && req_ready2) begin acc2 = cyc + 1; acc2_cnt++; end
    if (sram_addr_ready2 && !ar2_p) ar2_rise = cyc;
    if (sram_write_pulse2 && !wp2_p) wp2_rise = cyc;
    if (!sram_write_pulse2 && wp2_p) wp2_fall = cyc;
    if (resp_valid2) begin resp2_cyc = cyc; resp2_cnt++; end
    ar2_p = sram_addr_ready2; wp2_p = sram_write_pulse2;
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic op(input logic we, input logic [6:0] a, input logic [31:0] d);
    int n0, r0, k;
    n0 = acc_cnt; r0 = resp_cnt;
    req_we = we; req_addr = a; req_wdata = d; req_valid = 1'b1;
    k = 0;
    while (acc_cnt == n0 && k < 40) begin step(); k++; end
    req_valid = 1'b0;
    check_eq("op_accept", acc_cnt - n0, 1);
    k = 0;
    while (resp_cnt == r0 && k < 40) begin step(); k++; end
    check_eq("op_resp", resp_cnt - r0, 1);
    step();
  endtask

  initial begin
    int n0, r0, rr0, first, second, k;
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
    req_valid2 = 1'b0; req_we2 = 1'b0; req_addr2 = '0; req_wdata2 = '0;
    repeat (3) step();
    check_eq("rst_req_ready", req_ready, 1);
    check_eq("rst_resp_valid", resp_valid, 0);
    check_eq("rst_resp_rdata", resp_rdata, 0);
    check_eq("rst_sram_addr", sram_addr, 0);
    check_eq("rst_sram_datain", sram_datain, 0);
    check_eq("rst_strobes", {sram_addr_ready, sram_read_pulse, sram_write_pulse}, 0);
    rst_n = 1'b1;
    step();

    op(1'b1, 7'h05, 32'hDEADBEEF);
    check_eq("wr_ar_rise", ar_rise - acc_edge, 1);
    check_eq("wr_wp_rise", wp_rise - acc_edge, 2);
    check_eq("wr_wp_width", wp_fall - wp_rise, 2);
    check_eq("wr_resp_lat", resp_cyc - acc_edge, 5);

    op(1'b0, 7'h05, 32'h0);
    check_eq("rd_data_05", resp_data, 32'hDEADBEEF);
    check_eq("rd_rp_width", rp_fall - rp_rise, 2);
    check_eq("rd_resp_lat", resp_cyc - acc_edge, 5);

    op(1'b1, 7'h7F, 32'h12345678);
    op(1'b1, 7'h00, 32'hA5A5A5A5);
    check_eq("wr_keeps_rdata", resp_data, 32'hDEADBEEF);
    op(1'b0, 7'h7F, 32'h0);
    check_eq("rd_data_7f", resp_data, 32'h12345678);
    op(1'b0, 7'h00, 32'h0);
    check_eq("rd_data_00", resp_data, 32'hA5A5A5A5);

    // Back-to-back reads with req_valid held through the busy period
    n0 = acc_cnt; r0 = resp_cnt; rr0 = rp_rises;
    req_we = 1'b0; req_addr = 7'h05; req_valid = 1'b1;
    k = 0;
    while (acc_cnt == n0 && k < 40) begin step(); k++; end
    first = acc_edge;
    req_addr = 7'h7F;
    k = 0;
    while (acc_cnt < n0 + 2 && k < 40) begin step(); k++; end
    second = acc_edge;
    req_valid = 1'b0;
    k = 0;
    while (resp_cnt < r0 + 2 && k < 40) begin step(); k++; end
    repeat (4) step();
    check_eq("b2b_accepts", acc_cnt - n0, 2);
    check_eq("b2b_spacing", second - first, 7);
    check_eq("b2b_rpulses", rp_rises - rr0, 2);
    check_eq("b2b_resps", resp_cnt - r0, 2);
    check_eq("b2b_last_data", resp_data, 32'h12345678);

    // Reset during the write pulse
    req_we = 1'b1; req_addr = 7'h10; req_wdata = 32'h11111111; req_valid = 1'b1;
    k = 0;
    while (!sram_write_pulse && k < 40) begin step(); k++; end
    check_eq("rst_mid_reached_pulse", sram_write_pulse, 1);
    r0 = resp_cnt;
    req_valid = 1'b0; rst_n = 1'b0;
    step();
    check_eq("rst_mid_strobes", {sram_addr_ready, sram_read_pulse, sram_write_pulse}, 0);
    check_eq("rst_mid_req_ready", req_ready, 1);
    check_eq("rst_mid_resp_valid", resp_valid, 0);
    check_eq("rst_mid_sram_addr", sram_addr, 0);
    rst_n = 1'b1;
    repeat (8) step();
    check_eq("rst_mid_no_resp", resp_cnt - r0, 0);

    // Parameter sweep instance S=3, P=4
    n0 = acc2_cnt; r0 = resp2_cnt;
    req_we2 = 1'b1; req_addr2 = 7'h33; req_wdata2 = 32'hCAFEF00D; req_valid2 = 1'b1;
    k = 0;
    while (acc2_cnt == n0 && k < 40) begin step(); k++; end
    req_valid2 = 1'b0;
    k = 0;
    while (resp2_cnt == r0 && k < 40) begin step(); k++; end
    check_eq("s3p4_resp", resp2_cnt - r0, 1);
    check_eq("s3p4_ar_rise", ar2_rise - acc2, 3);
    check_eq("s3p4_wp_rise", wp2_rise - acc2, 4);
    check_eq("s3p4_wp_width", wp2_fall - wp2_rise, 4);
    check_eq("s3p4_resp_lat", resp2_cyc - acc2, 9);
    repeat (2) step();
    check_eq("s3p4_ready_back", req_ready2, 1);

    check_eq("protocol_violations", viol, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
